// File: rtl/timing_control_unit_if.sv
// rtl/timing_control_unit_if.sv - memory handshake and datapath load strobes between sequencer and datapath
//
// Signals:
//   mem_rd     sequencer -> memory    read request (T1 fetch, T3 indirect)
//   mem_ready  memory -> sequencer    acknowledge for the current mem_rd
//   ar_ld_pc   sequencer -> datapath  AR<-PC
//   ir_ld      sequencer -> datapath  IR<-M[AR]
//   pc_inc     sequencer -> datapath  PC<-PC+1
//   ar_ld_ir   sequencer -> datapath  AR<-IR(address)
//   ar_ld_mem  sequencer -> datapath  AR<-M[AR]
// Modports: master = sequencer side, slave = memory/datapath side.
interface timing_control_unit_if;
    logic mem_rd;
    logic mem_ready;
    logic ar_ld_pc;
    logic ir_ld;
    logic pc_inc;
    logic ar_ld_ir;
    logic ar_ld_mem;

    modport master (
        output mem_rd, ar_ld_pc, ir_ld, pc_inc, ar_ld_ir, ar_ld_mem,
        input  mem_ready
    );

    modport slave (
        input  mem_rd, ar_ld_pc, ir_ld, pc_inc, ar_ld_ir, ar_ld_mem,
        output mem_ready
    );
endinterface

// File: rtl/timing_control_unit.sv
// rtl/timing_control_unit.sv - instruction-cycle sequencer: sequence counter, T0..T7 decode, FETCH/DECODE/INDIRECT/EXECUTE
//
// Optional feature macro: INTR_CYCLE_EN (adds INTR state and intr_ack output).
// Ports:
//   clk, rst      clock (rising edge), synchronous active-high reset
//   start         leave IDLE/HALTED and begin fetch
//   ir_i          indirect bit of fetched instruction (valid from T2)
//   exec_done     current instruction finished (sampled T4..T7)
//   halt_req      HLT decoded, honoured together with exec_done
//   irq           interrupt request (only used with INTR_CYCLE_EN)
//   bus           memory handshake + datapath load strobes (master side)
//   sc            sequence counter
//   t             one-hot timing signals t[sc], zero when not running
//   running       sequencer is stepping an instruction (or interrupt cycle)
//   halted        sequencer is in HALTED
//   tmo           pulse: execute reached T7 without exec_done
//   intr_ack      (INTR_CYCLE_EN only) high in every INTR cycle
module timing_control_unit #(
    parameter int SC_W    = 3,
    parameter int EXEC_T0 = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   ir_i,
    input  logic                   exec_done,
    input  logic                   halt_req,
    input  logic                   irq,
    timing_control_unit_if.master  bus,
    output logic [SC_W-1:0]        sc,
    output logic [2**SC_W-1:0]     t,
    output logic                   running,
    output logic                   halted,
    output logic                   tmo
`ifdef INTR_CYCLE_EN
    ,
    output logic                   intr_ack
`endif
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        DECODE   = 3'd2,
        INDIRECT = 3'd3,
        EXECUTE  = 3'd4,
        HALTED   = 3'd5
`ifdef INTR_CYCLE_EN
        ,
        INTR     = 3'd6
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [SC_W-1:0] sc_q, sc_d;
    logic            boundary;

`ifndef INTR_CYCLE_EN
    logic unused_irq;
    assign unused_irq = irq;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sc_q    <= '0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sc_d          = sc_q;
        bus.mem_rd    = 1'b0;
        bus.ar_ld_pc  = 1'b0;
        bus.ir_ld     = 1'b0;
        bus.pc_inc    = 1'b0;
        bus.ar_ld_ir  = 1'b0;
        bus.ar_ld_mem = 1'b0;
        tmo           = 1'b0;
        boundary      = 1'b0;
`ifdef INTR_CYCLE_EN
        intr_ack      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                sc_d = '0;
                if (start) state_d = FETCH;
            end
            HALTED: begin
                sc_d = '0;
                if (start) state_d = FETCH;
`ifdef INTR_CYCLE_EN
                else if (irq) state_d = INTR;
`endif
            end
            FETCH: begin
                if (sc_q == '0) begin
                    bus.ar_ld_pc = 1'b1;
                    sc_d         = SC_W'(1);
                end else begin
                    // T1 stalls indefinitely until memory acknowledges
                    bus.mem_rd = 1'b1;
                    if (bus.mem_ready) begin
                        bus.ir_ld  = 1'b1;
                        bus.pc_inc = 1'b1;
                        sc_d       = SC_W'(2);
                        state_d    = DECODE;
                    end
                end
            end
            DECODE: begin
                bus.ar_ld_ir = 1'b1;
                sc_d         = SC_W'(3);
                state_d      = INDIRECT;
            end
            INDIRECT: begin
                if (!ir_i) begin
                    sc_d    = SC_W'(EXEC_T0);
                    state_d = EXECUTE;
                end else begin
                    bus.mem_rd = 1'b1;
                    if (bus.mem_ready) begin
                        bus.ar_ld_mem = 1'b1;
                        sc_d          = SC_W'(EXEC_T0);
                        state_d       = EXECUTE;
                    end
                end
            end
            EXECUTE: begin
                if (exec_done) begin
                    sc_d     = '0;
                    boundary = 1'b1;
                    state_d  = halt_req ? HALTED : FETCH;
                end else if (sc_q == '1) begin
                    // Out of timing slots: abandon the instruction and refetch
                    tmo      = 1'b1;
                    sc_d     = '0;
                    boundary = 1'b1;
                    state_d  = FETCH;
                end else begin
                    sc_d = sc_q + SC_W'(1);
                end
`ifdef INTR_CYCLE_EN
                if (boundary && irq && !halt_req) state_d = INTR;
`endif
            end
`ifdef INTR_CYCLE_EN
            INTR: begin
                intr_ack = 1'b1;
                if (sc_q == SC_W'(2)) begin
                    sc_d    = '0;
                    state_d = FETCH;
                end else begin
                    sc_d = sc_q + SC_W'(1);
                end
            end
`endif
            default: begin
                state_d = IDLE;
                sc_d    = '0;
            end
        endcase
    end

    assign running = (state_q != IDLE) && (state_q != HALTED);
    assign halted  = (state_q == HALTED);
    assign sc      = sc_q;
    assign t       = running ? ({{(2**SC_W-1){1'b0}}, 1'b1} << sc_q) : '0;

endmodule
